unary_add_seq: RTL and testbench
================================

# unary_add_seq

Controller that sequences a unary accumulator through one complete add operation. It accepts two binary operands on a start strobe, streams them into the accumulator as unary pulse trains (read phase), then drains the accumulator (write phase) while counting the returned pulses back into a binary result with an overflow flag. It sits between the binary control plane and the unary accumulator datapath and is the only driver of the accumulator's `en` and `read_or_write` controls.

## Interface
- `OPW`, default 8: operand width in bits.
- `ACC_W`, default 16: accumulator count width; must equal the attached accumulator's counter width.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin an operation; sampled only in IDLE.
- `op_a`, `op_b`  in  OPW: operands; captured on the accepted `start`.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse in DONE.
- `result`  out  ACC_W: sum modulo 2^ACC_W; valid from DONE, held until the next accepted `start`.
- `ovf`  out  1: sticky carry seen during the operation; same validity as `result`.
- `acc_en`, `acc_a`, `acc_b`, `acc_rw`  out  1 each: accumulator enable, unary inputs and phase select (0 = read, 1 = write).
- `acc_dout`, `acc_c`  in  1 each: accumulator drain pulse and carry, both registered inside the accumulator.

## Operation
- States: IDLE, LOAD, DRAIN, DONE. The `acc_*` outputs are Moore outputs decoded from the state and the remaining-count registers.
- IDLE: `acc_en` = 0. On `start`, load `rem_a`/`rem_b` from `op_a`/`op_b`, clear `result`/`ovf`, then go to LOAD. If both operands are 0, go directly to DRAIN.
- LOAD: `acc_en` = 1, `acc_rw` = 0.
  - `acc_a` = (`rem_a` != 0) and `acc_b` = (`rem_b` != 0).
  - Each nonzero remaining count decrements by 1 per cycle.
  - Exit to DRAIN after the cycle in which both counts are ≤ 1. LOAD therefore lasts max(op_a, op_b) cycles.
- DRAIN: `acc_en` = 1, `acc_rw` = 1, `acc_a` = `acc_b` = 0.
  - The first DRAIN cycle does not sample `acc_dout`.
  - From the second cycle on: if `acc_dout` = 1, increment `result` (ACC_W wrap). If `acc_dout` = 0, go to DONE.
  - DRAIN lasts S+2 cycles, where S = (op_a + op_b) mod 2^ACC_W.
- DONE: `acc_en` = 0, `done` = 1, then go to IDLE.
- `ovf` is set (sticky) whenever `acc_c` = 1 in any LOAD or DRAIN cycle.
- `start` outside IDLE is ignored. There is no queueing.
- The accumulator is left at count 0 after every operation, so back-to-back operations need no flush.

## Timing
- Reset: state = IDLE; `busy`, `done`, `ovf`, `acc_en`, `acc_a`, `acc_b`, `acc_rw` = 0; `result` = 0; remaining counts = 0.
- Latency: with `start` in cycle 0, DONE occurs in cycle 1 + max(op_a, op_b) + S + 2.
- `start` may be asserted in the cycle after DONE; the block is back in IDLE then.
- Reset mid-operation returns the controller to IDLE immediately. The accumulator shares `rst_n`, so both restart clean.

## Configuration
- `UNARY_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit).
  - `abort` = 1 in LOAD clears both remaining counts and goes to DRAIN next cycle. The partial sum is drained and reported normally.
  - `aborted` is set with that transition and is held until the next accepted `start`.
  - `abort` is ignored in IDLE, DRAIN and DONE.
- Not defined: neither port exists, and LOAD always runs to completion.

## Structure
- Package `unary_seq_pkg`: state enum (IDLE/LOAD/DRAIN/DONE) and the `acc_rw` phase constants (READ = 0, WRITE = 1).
- Sub-module `unary_stream_gen`, instanced twice (A and B): a loadable down-counter that emits 1 while nonzero. It has load, enable and clear inputs, plus `bit` and `last` outputs.

## Test plan
- Reset, then `op_a` = 3, `op_b` = 5, `start` at cycle 0 (OPW = 8, ACC_W = 16). Expect LOAD in cycles 1–5, DRAIN in cycles 6–15, `done` in cycle 16, `result` = 8, `ovf` = 0.
- `op_a` = 0, `op_b` = 0: expect no LOAD, DRAIN for 2 cycles, `done` in cycle 3, `result` = 0.
- `op_a` = 7, `op_b` = 0, repeated back-to-back with `start` in the cycle after `done`. Expect `result` = 7 both times, confirming the accumulator returns to 0.
- OPW = 16: `op_a` = `op_b` = 40000. Expect `result` = 14464 and `ovf` = 1.
- `start` pulsed during LOAD and during DRAIN: ignored, and the result is unchanged. Drop `rst_n` mid-DRAIN: all outputs return to reset values asynchronously.
- With `UNARY_SEQ_ABORT_EN`: `op_a` = `op_b` = 10, `abort` in the 4th LOAD cycle. Expect `result` = 8, `aborted` = 1, and `done` to follow.

Source files
------------

// File: rtl/unary_add_seq_pkg.sv
// Shared types for the unary add sequencer: controller states and accumulator phase encoding.
package unary_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/unary_add_seq_if.sv
// Control-plane and accumulator-facing signals of unary_add_seq; slave = sequencer, master = environment.
// Optional abort/aborted exist only when UNARY_SEQ_ABORT_EN is defined.
interface unary_add_seq_if #(parameter int OPW = 8, parameter int ACC_W = 16);
  logic             start;
  logic [OPW-1:0]   op_a, op_b;
  logic             busy, done;
  logic [ACC_W-1:0] result;
  logic             ovf;
  logic             acc_en, acc_a, acc_b, acc_rw;
  logic             acc_dout, acc_c;
`ifdef UNARY_SEQ_ABORT_EN
  logic             abort, aborted;

  modport slave (input start, op_a, op_b, acc_dout, acc_c, abort,
                 output busy, done, result, ovf, acc_en, acc_a, acc_b, acc_rw, aborted);
  modport master (output start, op_a, op_b, acc_dout, acc_c, abort,
                  input busy, done, result, ovf, acc_en, acc_a, acc_b, acc_rw, aborted);
`else
  modport slave (input start, op_a, op_b, acc_dout, acc_c,
                 output busy, done, result, ovf, acc_en, acc_a, acc_b, acc_rw);
  modport master (output start, op_a, op_b, acc_dout, acc_c,
                  input busy, done, result, ovf, acc_en, acc_a, acc_b, acc_rw);
`endif
endinterface

// File: rtl/unary_add_seq_stream_gen.sv
// Loadable down-counter that emits one unary pulse per remaining count.
module unary_stream_gen #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic         bit_o,
  output logic         last_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (clr_i)                 cnt_q <= '0;
    else if (load_i)                cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign bit_o  = (cnt_q != '0);
  // last: this cycle's pulse (if any) is the final one
  assign last_o = (cnt_q <= W'(1));
endmodule

// File: rtl/unary_add_seq.sv
// Sequences a unary accumulator through one add: stream operands in (LOAD), count drain pulses back (DRAIN).
// Optional abort during LOAD: define UNARY_SEQ_ABORT_EN.
module unary_add_seq
  import unary_seq_pkg::*;
#(
  parameter int OPW   = 8,
  parameter int ACC_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  unary_add_seq_if.slave io
);
  state_e           state_q, state_d;
  logic             first_q;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             aborted_q, aborted_d;
  logic             ld, dec, clr;
  logic [1:0]       bit_v, last_v;
  logic [1:0][OPW-1:0] op_v;

  assign op_v = {io.op_b, io.op_a};

  for (genvar i = 0; i < 2; i++) begin : g_str
    unary_stream_gen #(.W(OPW)) u_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ld),
      .load_val_i (op_v[i]),
      .en_i       (dec),
      .clr_i      (clr),
      .bit_o      (bit_v[i]),
      .last_o     (last_v[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      first_q   <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= (state_d == DRAIN) && (state_q != DRAIN);
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    aborted_d = aborted_q;
    ld        = 1'b0;
    dec       = 1'b0;
    clr       = 1'b0;
    if ((state_q == LOAD || state_q == DRAIN) && io.acc_c) ovf_d = 1'b1;
    unique case (state_q)
      IDLE: if (io.start) begin
        ld        = 1'b1;
        result_d  = '0;
        ovf_d     = 1'b0;
        aborted_d = 1'b0;
        state_d   = (io.op_a == '0 && io.op_b == '0) ? DRAIN : LOAD;
      end
      LOAD: begin
        dec = 1'b1;
`ifdef UNARY_SEQ_ABORT_EN
        if (io.abort) begin
          clr       = 1'b1;
          aborted_d = 1'b1;
          state_d   = DRAIN;
        end else
`endif
        if (last_v[0] && last_v[1]) state_d = DRAIN;
      end
      // drain pulse is registered in the accumulator, so the first cycle has nothing to count
      DRAIN: if (!first_q) begin
        if (io.acc_dout) result_d = result_q + ACC_W'(1);
        else             state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign io.busy   = (state_q != IDLE);
  assign io.done   = (state_q == DONE);
  assign io.result = result_q;
  assign io.ovf    = ovf_q;
  assign io.acc_en = (state_q == LOAD) || (state_q == DRAIN);
  assign io.acc_rw = (state_q == DRAIN) ? RW_WRITE : RW_READ;
  assign io.acc_a  = (state_q == LOAD) && bit_v[0];
  assign io.acc_b  = (state_q == LOAD) && bit_v[1];
`ifdef UNARY_SEQ_ABORT_EN
  assign io.aborted = aborted_q;
`endif
endmodule

// File: tb/tb_unary_add_seq.sv
// Directed bench for unary_add_seq with a behavioural unary accumulator attached to each instance.
module tb_unary_add_seq;
  logic clk, rst_n;
  int   n_chk, n_err;

  unary_add_seq_if #(.OPW(8),  .ACC_W(16)) if0 ();
  unary_add_seq_if #(.OPW(16), .ACC_W(16)) if1 ();

  unary_add_seq #(.OPW(8),  .ACC_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0));
  unary_add_seq #(.OPW(16), .ACC_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator model: read phase adds a+b with registered carry, write phase emits one pulse per count.
  logic [15:0] cnt0, cnt1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0; if0.acc_dout <= 1'b0; if0.acc_c <= 1'b0;
    end else if (if0.acc_en && !if0.acc_rw) begin
      {if0.acc_c, cnt0} <= {1'b0, cnt0} + 17'(if0.acc_a) + 17'(if0.acc_b);
      if0.acc_dout <= 1'b0;
    end else if (if0.acc_en) begin
      if0.acc_c <= 1'b0;
      if0.acc_dout <= (cnt0 != 0);
      if (cnt0 != 0) cnt0 <= cnt0 - 16'd1;
    end else begin
      if0.acc_dout <= 1'b0; if0.acc_c <= 1'b0;
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0; if1.acc_dout <= 1'b0; if1.acc_c <= 1'b0;
    end else if (if1.acc_en && !if1.acc_rw) begin
      {if1.acc_c, cnt1} <= {1'b0, cnt1} + 17'(if1.acc_a) + 17'(if1.acc_b);
      if1.acc_dout <= 1'b0;
    end else if (if1.acc_en) begin
      if1.acc_c <= 1'b0;
      if1.acc_dout <= (cnt1 != 0);
      if (cnt1 != 0) cnt1 <= cnt1 - 16'd1;
    end else begin
      if1.acc_dout <= 1'b0; if1.acc_c <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Called at a negedge while dut0 is IDLE; returns at the negedge of the DONE cycle.
  task automatic run0(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input int e_res, input int e_ovf, input int e_ln, input int e_dn,
                      input int e_dk, input bit glitch, input int abk);
    int k, ln, dn, dk;
    ln = 0; dn = 0; dk = 0;
    if0.op_a = a; if0.op_b = b; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    k = 1;
    while (k < 2000) begin
      if (if0.done) begin dk = k; break; end
      if (if0.acc_en && !if0.acc_rw) ln++;
      if (if0.acc_en &&  if0.acc_rw) dn++;
      if0.start = glitch && (k == 2 || k == e_ln + 2);
      if (glitch) begin if0.op_a = 8'd99; if0.op_b = 8'd99; end
`ifdef UNARY_SEQ_ABORT_EN
      if0.abort = (abk != 0) && (k == abk);
`endif
      @(negedge clk);
      k++;
    end
    if0.start = 1'b0;
`ifdef UNARY_SEQ_ABORT_EN
    if0.abort = 1'b0;
    chk({tag, ".aborted"}, 32'(if0.aborted), 32'(abk != 0));
`endif
    chk({tag, ".done_cyc"}, 32'(dk), 32'(e_dk));
    chk({tag, ".load_n"},   32'(ln), 32'(e_ln));
    chk({tag, ".drain_n"},  32'(dn), 32'(e_dn));
    chk({tag, ".result"},   32'(if0.result), 32'(e_res));
    chk({tag, ".ovf"},      32'(if0.ovf), 32'(e_ovf));
  endtask

  initial begin
    int k;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    if0.start = 1'b0; if0.op_a = '0; if0.op_b = '0;
    if1.start = 1'b0; if1.op_a = '0; if1.op_b = '0;
`ifdef UNARY_SEQ_ABORT_EN
    if0.abort = 1'b0; if1.abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst.busy",   32'(if0.busy), 0);
    chk("rst.done",   32'(if0.done), 0);
    chk("rst.ovf",    32'(if0.ovf), 0);
    chk("rst.result", 32'(if0.result), 0);
    chk("rst.acc",    32'({if0.acc_en, if0.acc_a, if0.acc_b, if0.acc_rw}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run0("a3b5", 8'd3, 8'd5, 8, 0, 5, 10, 16, 1'b0, 0);
    @(negedge clk);
    chk("a3b5.done_pulse", 32'(if0.done), 0);
    chk("a3b5.held",       32'(if0.result), 8);
    run0("a0b0", 8'd0, 8'd0, 0, 0, 0, 2, 3, 1'b0, 0);
    @(negedge clk);
    run0("a7b0_1", 8'd7, 8'd0, 7, 0, 7, 9, 17, 1'b0, 0);
    @(negedge clk);
    chk("b2b.idle", 32'(if0.busy), 0);
    run0("a7b0_2", 8'd7, 8'd0, 7, 0, 7, 9, 17, 1'b0, 0);
    @(negedge clk);
    run0("glitch", 8'd4, 8'd2, 6, 0, 4, 8, 13, 1'b1, 0);
    @(negedge clk);
    run0("max8", 8'd255, 8'd255, 510, 0, 255, 512, 768, 1'b0, 0);
    @(negedge clk);

    // asynchronous reset in the middle of DRAIN (cycle 8 of a 3+5 add)
    if0.op_a = 8'd3; if0.op_b = 8'd5; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid.busy",  32'(if0.busy), 1);
    chk("mid.drain", 32'(if0.acc_rw), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy",   32'(if0.busy), 0);
    chk("arst.result", 32'(if0.result), 0);
    chk("arst.acc",    32'({if0.acc_en, if0.acc_a, if0.acc_b, if0.acc_rw}), 0);
    chk("arst.flags",  32'({if0.done, if0.ovf}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run0("post_rst", 8'd3, 8'd5, 8, 0, 5, 10, 16, 1'b0, 0);
    @(negedge clk);

`ifdef UNARY_SEQ_ABORT_EN
    run0("abort", 8'd10, 8'd10, 8, 0, 4, 10, 15, 1'b0, 4);
    @(negedge clk);
`endif

    // 16-bit operands: 40000+40000 wraps to 14464 with carry
    if1.op_a = 16'd40000; if1.op_b = 16'd40000; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    k = 1;
    while (!if1.done && k < 60000) begin
      @(negedge clk);
      k++;
    end
    chk("w16.done_cyc", 32'(k), 54467);
    chk("w16.result",   32'(if1.result), 14464);
    chk("w16.ovf",      32'(if1.ovf), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
